// File: rtl/sram_port_arbiter.sv
// ============================================================================
// sram_port_arbiter
// ----------------------------------------------------------------------------
// Shares one external asynchronous SRAM port between two requesters:
//   * a pixel-fetch reader (rd_*)
//   * a result write-back writer (wr_*)
// Each access drives a registered address and a registered strobe, and holds
// the strobe for ACCESS_CYCLES cycles, which covers the SRAM wait states. When
// the access ends, the requester receives a one-cycle acknowledge. For reads,
// rd_data is captured from the SRAM bus on the final access edge. When both
// sides are pending, the grant alternates round-robin.
//
// Optional build macro:
//   SRAM_ARB_TURNAROUND_EN - inserts a one-cycle TURN state, with both strobes
//                            low, when the bus direction changes. Without it,
//                            a direction change costs nothing.
//
// Parameters:
//   ADDR_BITS      SRAM address width
//   DATA_BITS      SRAM data word width (one RGB pixel)
//   ACCESS_CYCLES  cycles each strobe stays high (1..255)
//
// Ports:
//   clk           system clock, rising edge
//   rst           asynchronous reset, active-high
//   rd_req        read request level, held with rd_addr until rd_ack
//   rd_addr       read address
//   rd_ack        one-cycle read acknowledge; rd_data valid in same cycle
//   rd_data       registered read data, held until the next read completes
//   wr_req        write request level, held with wr_addr/wr_data until wr_ack
//   wr_addr       write address
//   wr_data       write data
//   wr_ack        one-cycle write-complete acknowledge
//   address       registered SRAM address
//   w_data        registered SRAM write data
//   r_data        SRAM read data bus
//   read_enable   registered SRAM read strobe
//   write_enable  registered SRAM write strobe
//   busy          high whenever the arbiter is not idle
// ============================================================================

`default_nettype none

module sram_port_arbiter #(
    parameter int ADDR_BITS     = 16,
    parameter int DATA_BITS     = 24,
    parameter int ACCESS_CYCLES = 10
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 rd_req,
    input  logic [ADDR_BITS-1:0] rd_addr,
    output logic                 rd_ack,
    output logic [DATA_BITS-1:0] rd_data,

    input  logic                 wr_req,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [DATA_BITS-1:0] wr_data,
    output logic                 wr_ack,

    output logic [ADDR_BITS-1:0] address,
    output logic [DATA_BITS-1:0] w_data,
    input  logic [DATA_BITS-1:0] r_data,
    output logic                 read_enable,
    output logic                 write_enable,
    output logic                 busy
);

`ifdef SRAM_ARB_TURNAROUND_EN
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        READ_ACC  = 2'd1,
        WRITE_ACC = 2'd2,
        TURN      = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        READ_ACC  = 2'd1,
        WRITE_ACC = 2'd2
    } state_t;
`endif

    // The counter runs 0..ACCESS_CYCLES-1 and never wraps. The access ends
    // on the edge where it reaches the last value.
    localparam logic [7:0] LAST_CNT = 8'(ACCESS_CYCLES - 1);

    // Direction encoding, shared by last_grant and the turnaround tracker.
    localparam logic DIR_RD = 1'b0;
    localparam logic DIR_WR = 1'b1;

    state_t                 state_q, state_d;
    logic [7:0]             cnt_q, cnt_d;
    logic                   last_grant_q, last_grant_d;
    logic [ADDR_BITS-1:0]   address_q, address_d;
    logic [DATA_BITS-1:0]   w_data_q, w_data_d;
    logic [DATA_BITS-1:0]   rd_data_q, rd_data_d;
    logic                   read_enable_q, read_enable_d;
    logic                   write_enable_q, write_enable_d;
    logic                   rd_ack_q, rd_ack_d;
    logic                   wr_ack_q, wr_ack_d;

    logic                   rd_pend;
    logic                   wr_pend;
    logic                   grant_rd;
    logic                   grant_wr;
    logic                   access_done;
    logic                   turn_rd;
    logic                   turn_wr;

    // While the ack cycle is in progress, a requester has not yet had a
    // chance to present its next address. Masking its request for that one
    // cycle stops the arbiter from re-granting it on stale inputs. The other
    // side can still win the bus in that same cycle.
    assign rd_pend = rd_req & ~rd_ack_q;
    assign wr_pend = wr_req & ~wr_ack_q;

    // Round-robin: under contention, the side that did not win last time
    // gets the bus. The two grant terms are mutually exclusive by
    // construction.
    assign grant_rd = (state_q == IDLE) & rd_pend & (~wr_pend | (last_grant_q == DIR_WR));
    assign grant_wr = (state_q == IDLE) & wr_pend & (~rd_pend | (last_grant_q == DIR_RD));

    assign access_done = ((state_q == READ_ACC) || (state_q == WRITE_ACC)) && (cnt_q == LAST_CNT);

`ifdef SRAM_ARB_TURNAROUND_EN
    // These track the direction of the last completed access. have_dir_q
    // stays clear until the first access after reset finishes, so that
    // first access never pays the turnaround cycle.
    logic last_dir_q, last_dir_d;
    logic have_dir_q, have_dir_d;

    assign turn_rd = have_dir_q & (last_dir_q != DIR_RD);
    assign turn_wr = have_dir_q & (last_dir_q != DIR_WR);

    // This register holds the turnaround history. It is cleared with the
    // rest of the block on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_dir_q <= DIR_RD;
            have_dir_q <= 1'b0;
        end else begin
            last_dir_q <= last_dir_d;
            have_dir_q <= have_dir_d;
        end
    end
`else
    assign turn_rd = 1'b0;
    assign turn_wr = 1'b0;
`endif

    // State register plus all registered outputs and datapath. Reset is
    // asynchronous, so an access in flight is abandoned immediately and no
    // ack is issued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            cnt_q          <= 8'd0;
            last_grant_q   <= DIR_WR;
            address_q      <= '0;
            w_data_q       <= '0;
            rd_data_q      <= '0;
            read_enable_q  <= 1'b0;
            write_enable_q <= 1'b0;
            rd_ack_q       <= 1'b0;
            wr_ack_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            last_grant_q   <= last_grant_d;
            address_q      <= address_d;
            w_data_q       <= w_data_d;
            rd_data_q      <= rd_data_d;
            read_enable_q  <= read_enable_d;
            write_enable_q <= write_enable_d;
            rd_ack_q       <= rd_ack_d;
            wr_ack_q       <= wr_ack_d;
        end
    end

    // Next-state logic. IDLE arbitrates. Each access state leaves when the
    // counter reaches its last value. TURN always lasts exactly one cycle and
    // then enters the access state that was already granted.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (grant_rd) begin
`ifdef SRAM_ARB_TURNAROUND_EN
                    state_d = turn_rd ? TURN : READ_ACC;
`else
                    state_d = READ_ACC;
`endif
                end else if (grant_wr) begin
`ifdef SRAM_ARB_TURNAROUND_EN
                    state_d = turn_wr ? TURN : WRITE_ACC;
`else
                    state_d = WRITE_ACC;
`endif
                end
            end
            READ_ACC, WRITE_ACC: begin
                if (access_done) begin
                    state_d = IDLE;
                end
            end
`ifdef SRAM_ARB_TURNAROUND_EN
            TURN: begin
                state_d = (last_grant_q == DIR_WR) ? WRITE_ACC : READ_ACC;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath next values. Address and write data are loaded on
    // the grant edge and then held, including through IDLE. Acks default to
    // low, so each ack lasts exactly one cycle.
    always_comb begin
        cnt_d          = cnt_q;
        last_grant_d   = last_grant_q;
        address_d      = address_q;
        w_data_d       = w_data_q;
        rd_data_d      = rd_data_q;
        read_enable_d  = read_enable_q;
        write_enable_d = write_enable_q;
        rd_ack_d       = 1'b0;
        wr_ack_d       = 1'b0;
`ifdef SRAM_ARB_TURNAROUND_EN
        last_dir_d     = last_dir_q;
        have_dir_d     = have_dir_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (grant_rd) begin
                    address_d     = rd_addr;
                    cnt_d         = 8'd0;
                    last_grant_d  = DIR_RD;
                    read_enable_d = ~turn_rd;
                end else if (grant_wr) begin
                    address_d      = wr_addr;
                    w_data_d       = wr_data;
                    cnt_d          = 8'd0;
                    last_grant_d   = DIR_WR;
                    write_enable_d = ~turn_wr;
                end
            end
            READ_ACC, WRITE_ACC: begin
                if (access_done) begin
                    read_enable_d  = 1'b0;
                    write_enable_d = 1'b0;
                    if (state_q == READ_ACC) begin
                        rd_data_d = r_data;
                        rd_ack_d  = 1'b1;
                    end else begin
                        wr_ack_d  = 1'b1;
                    end
`ifdef SRAM_ARB_TURNAROUND_EN
                    last_dir_d = (state_q == WRITE_ACC) ? DIR_WR : DIR_RD;
                    have_dir_d = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
`ifdef SRAM_ARB_TURNAROUND_EN
            TURN: begin
                // The bus was idle for one cycle with the new address
                // already driven. The strobe for the granted direction
                // rises now.
                read_enable_d  = (last_grant_q == DIR_RD);
                write_enable_d = (last_grant_q == DIR_WR);
            end
`endif
            default: ;
        endcase
    end

    assign address      = address_q;
    assign w_data       = w_data_q;
    assign rd_data      = rd_data_q;
    assign read_enable  = read_enable_q;
    assign write_enable = write_enable_q;
    assign rd_ack       = rd_ack_q;
    assign wr_ack       = wr_ack_q;
    assign busy         = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_sram_port_arbiter.sv
// ============================================================================
// tb_sram_port_arbiter
// ----------------------------------------------------------------------------
// Self-checking bench for sram_port_arbiter, with ACCESS_CYCLES = 4.
//
// The stimulus thread drives the requesters. For every access it expects,
// it pushes an entry holding the hand-computed access address, data and ack
// cycle. A monitor samples the DUT on falling edges, records what each strobe
// window looked like, and checks that record against the head of the queue
// whenever an ack appears.
// ============================================================================

`timescale 1ns/1ps

module tb_sram_port_arbiter;

    localparam int AB = 16;
    localparam int DB = 24;
    localparam int AC = 4;
`ifdef SRAM_ARB_TURNAROUND_EN
    localparam int TP = 1;
`else
    localparam int TP = 0;
`endif

    logic          clk;
    logic          rst;
    logic          rd_req;
    logic [AB-1:0] rd_addr;
    logic          rd_ack;
    logic [DB-1:0] rd_data;
    logic          wr_req;
    logic [AB-1:0] wr_addr;
    logic [DB-1:0] wr_data;
    logic          wr_ack;
    logic [AB-1:0] address;
    logic [DB-1:0] w_data;
    logic [DB-1:0] r_data;
    logic          read_enable;
    logic          write_enable;
    logic          busy;

    sram_port_arbiter #(
        .ADDR_BITS    (AB),
        .DATA_BITS    (DB),
        .ACCESS_CYCLES(AC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rd_req      (rd_req),
        .rd_addr     (rd_addr),
        .rd_ack      (rd_ack),
        .rd_data     (rd_data),
        .wr_req      (wr_req),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_ack      (wr_ack),
        .address     (address),
        .w_data      (w_data),
        .r_data      (r_data),
        .read_enable (read_enable),
        .write_enable(write_enable),
        .busy        (busy)
    );

    typedef struct {
        bit            isWrite;
        logic [AB-1:0] addr;
        logic [DB-1:0] data;
        int            ackCycle;
    } expT;

    expT sbQ[$];

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    logic [AB-1:0] rdCapAddr;
    logic [AB-1:0] wrCapAddr;
    logic [DB-1:0] wrCapData;
    int            rdEnCnt;
    int            wrEnCnt;
    bit            bothEn;
    bit            busyLow;

    // This is a free-running clock plus an edge counter. Expected ack times
    // are expressed in this counter's units.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // This watchdog guarantees termination even if the bench logic hangs.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: actual=%0h required=%0h (cycle %0d)",
                     name, actual, expected, cyc);
        end
    endtask

    task automatic applyStimulus(input bit isWrite, input logic [AB-1:0] addr,
                                 input logic [DB-1:0] data);
        if (isWrite) begin
            wr_addr = addr;
            wr_data = data;
            wr_req  = 1'b1;
        end else begin
            rd_addr = addr;
            r_data  = data;
            rd_req  = 1'b1;
        end
    endtask

    task automatic pushExp(input bit isWrite, input logic [AB-1:0] addr,
                           input logic [DB-1:0] data, input int ackCycle);
        expT e;
        e.isWrite  = isWrite;
        e.addr     = addr;
        e.data     = data;
        e.ackCycle = ackCycle;
        sbQ.push_back(e);
    endtask

    // This task returns on the falling edge of the ack cycle. A missing ack
    // is counted as a failed comparison, and the bench then carries on.
    task automatic waitAck(input bit isWrite);
        int  n    = 0;
        bit  seen = 1'b0;
        while (!seen && n < 60) begin
            @(negedge clk);
            n++;
            seen = isWrite ? wr_ack : rd_ack;
        end
        if (!seen) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL ackTimeout: actual=none required=%s ack",
                     isWrite ? "write" : "read");
        end
    endtask

    task automatic clearMon();
        rdEnCnt = 0;
        wrEnCnt = 0;
        bothEn  = 1'b0;
        busyLow = 1'b0;
    endtask

    task automatic checkAck(input bit isWrite);
        expT e;
        if (sbQ.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL unexpectedAck: actual=%s ack required=no ack (cycle %0d)",
                     isWrite ? "write" : "read", cyc);
        end else begin
            e = sbQ.pop_front();
            checkOutput("ackKind", 32'(isWrite), 32'(e.isWrite));
            checkOutput("ackCycle", cyc, e.ackCycle);
            checkOutput("accAddr", 32'(isWrite ? wrCapAddr : rdCapAddr), 32'(e.addr));
            checkOutput("accData", 32'(isWrite ? wrCapData : rd_data), 32'(e.data));
            checkOutput("enCycles", isWrite ? wrEnCnt : rdEnCnt, AC);
            checkOutput("busyInAck", 32'(busy), 32'd0);
            checkOutput("enOverlap", 32'(bothEn), 32'd0);
            checkOutput("busyDuringEn", 32'(busyLow), 32'd0);
        end
        if (isWrite) wrEnCnt = 0;
        else         rdEnCnt = 0;
        bothEn  = 1'b0;
        busyLow = 1'b0;
    endtask

    // The monitor samples on each falling edge, away from the active edge.
    // It records the first address and data of each strobe window and how
    // long the window lasted, and scores the window when its ack appears.
    initial begin
        clearMon();
        forever begin
            @(negedge clk);
            if (rst) begin
                clearMon();
            end else begin
                if (read_enable) begin
                    if (rdEnCnt == 0) rdCapAddr = address;
                    rdEnCnt++;
                end
                if (write_enable) begin
                    if (wrEnCnt == 0) begin
                        wrCapAddr = address;
                        wrCapData = w_data;
                    end
                    wrEnCnt++;
                end
                if (read_enable && write_enable) bothEn = 1'b1;
                if ((read_enable || write_enable) && !busy) busyLow = 1'b1;
                if (rd_ack) checkAck(1'b0);
                if (wr_ack) checkAck(1'b1);
            end
        end
    end

    task automatic doReset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("rdDataReset", 32'(rd_data), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int base;
        int g;
        int n;
        rst     = 1'b1;
        rd_req  = 1'b0;
        wr_req  = 1'b0;
        rd_addr = '0;
        wr_addr = '0;
        wr_data = '0;
        r_data  = '0;

        // Reset state.
        @(negedge clk);
        checkOutput("rstReadEn",  32'(read_enable),  32'd0);
        checkOutput("rstWriteEn", 32'(write_enable), 32'd0);
        checkOutput("rstRdAck",   32'(rd_ack),       32'd0);
        checkOutput("rstWrAck",   32'(wr_ack),       32'd0);
        checkOutput("rstAddr",    32'(address),      32'd0);
        checkOutput("rstWData",   32'(w_data),       32'd0);
        checkOutput("rstRdData",  32'(rd_data),      32'd0);
        checkOutput("rstBusy",    32'(busy),         32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // A single read.
        $display("[TB] single read");
        applyStimulus(1'b0, 16'h0010, 24'hAABBCC);
        pushExp(1'b0, 16'h0010, 24'hAABBCC, cyc + AC + 1);
        waitAck(1'b0);
        @(posedge clk);
        #1;
        rd_req = 1'b0;

        // A single write, which is also a direction change.
        $display("[TB] single write");
        applyStimulus(1'b1, 16'h0100, 24'h123456);
        pushExp(1'b1, 16'h0100, 24'h123456, cyc + AC + 1 + TP);
        waitAck(1'b1);
        @(posedge clk);
        #1;
        wr_req = 1'b0;
        checkOutput("rdDataHeld",   32'(rd_data),     32'hAABBCC);
        checkOutput("addrHeldIdle", 32'(address),     32'h0100);
        checkOutput("idleReadEn",   32'(read_enable), 32'd0);

        // Both requests arrive together straight out of reset. The read goes
        // first, and the grants then alternate with no gap after each ack.
        $display("[TB] contention from reset");
        doReset();
        base = cyc;
        applyStimulus(1'b0, 16'h0200, 24'h111111);
        applyStimulus(1'b1, 16'h0300, 24'h222222);
        pushExp(1'b0, 16'h0200, 24'h111111, base + (AC + 1));
        pushExp(1'b1, 16'h0300, 24'h222222, base + (AC + 1) + 1 * (AC + 1 + TP));
        pushExp(1'b0, 16'h0200, 24'h111111, base + (AC + 1) + 2 * (AC + 1 + TP));
        pushExp(1'b1, 16'h0300, 24'h222222, base + (AC + 1) + 3 * (AC + 1 + TP));
        waitAck(1'b0);
        waitAck(1'b1);
        waitAck(1'b0);
        @(posedge clk);
        #1;
        rd_req = 1'b0;
        waitAck(1'b1);
        @(posedge clk);
        #1;
        wr_req = 1'b0;

        // Back-to-back reads from a requester that advances its address one
        // cycle after each ack. The masked ack cycle stops a stale regrant,
        // so each later access starts one idle cycle after the ack.
        $display("[TB] back-to-back reads");
        base = cyc;
        for (int i = 0; i < 3; i++) begin
            pushExp(1'b0, 16'h0400 + 16'(i), 24'hC00000 + 24'(i),
                    base + AC + 1 + TP + i * (AC + 2));
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 16'h0400 + 16'(i), 24'hC00000 + 24'(i));
            waitAck(1'b0);
            @(posedge clk);
            #1;
        end
        rd_req = 1'b0;

        // Reset arrives in the second strobe cycle of a write while a read is
        // waiting. The write is dropped with no ack, and the read is then
        // served normally.
        $display("[TB] reset during write");
        applyStimulus(1'b1, 16'h0500, 24'h777777);
        applyStimulus(1'b0, 16'h0600, 24'h999999);
        n = 0;
        while (!write_enable && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("wrEnStart", 32'(write_enable), 32'd1);
        @(posedge clk);
        #3;
        checkOutput("wrEnSecond", 32'(write_enable), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("asyncWrEn", 32'(write_enable), 32'd0);
        checkOutput("asyncRdEn", 32'(read_enable),  32'd0);
        checkOutput("asyncAddr", 32'(address),      32'd0);
        checkOutput("asyncWData", 32'(w_data),      32'd0);
        checkOutput("asyncBusy", 32'(busy),         32'd0);
        checkOutput("asyncWrAck", 32'(wr_ack),      32'd0);
        wr_req = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        pushExp(1'b0, 16'h0600, 24'h999999, cyc + AC + 1);
        waitAck(1'b0);
        @(posedge clk);
        #1;
        rd_req = 1'b0;

        // A write followed by a read. The gap is measured from the write ack
        // to the rising read strobe, and it grows by the turnaround cycle
        // when that feature is built in.
        $display("[TB] write then read");
        base = cyc;
        applyStimulus(1'b1, 16'h0700, 24'hABCDEF);
        applyStimulus(1'b0, 16'h0800, 24'h5A5A5A);
        pushExp(1'b1, 16'h0700, 24'hABCDEF, base + (AC + 1 + TP));
        pushExp(1'b0, 16'h0800, 24'h5A5A5A, base + 2 * (AC + 1 + TP));
        waitAck(1'b1);
        @(posedge clk);
        #1;
        wr_req = 1'b0;
        g = 1;
        while (!read_enable && g < 10) begin
            @(posedge clk);
            #1;
            g++;
        end
        checkOutput("turnGap", g, 1 + TP);
        waitAck(1'b0);
        @(posedge clk);
        #1;
        rd_req = 1'b0;

        repeat (10) @(posedge clk);
        #1;
        checkOutput("sbDrained", sbQ.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
